// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single on-chip memory port between the
// boot/system controller (S) and the RISC-V core (C), one transaction at a time.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   bus_owner, owner_lock    0 = S owns the bus, 1 = C owns; lock blocks the non-owner
//   s_*/c_* req/wen/addr/    requester side: request held with its fields until gnt
//     wdata/strb
//   s_*/c_* gnt/rvalid/      one-cycle grant pulse, one-cycle response pulse
//     rdata/err                with read data and timeout flag
//   mem_req/wen/addr/        memory side: request held until mem_gnt,
//     wdata/strb, mem_gnt      fields latched at arbitration
//   mem_rvalid, mem_rdata    memory response (reads and writes)
//   busy                     arbiter is not idle
module mem_bus_arbiter #(
    parameter int RSP_TIMEOUT  = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bus_owner,
    input  logic        owner_lock,
    input  logic        s_req,
    input  logic        s_wen,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_strb,
    output logic        s_gnt,
    output logic        s_rvalid,
    output logic [31:0] s_rdata,
    output logic        s_err,
    input  logic        c_req,
    input  logic        c_wen,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_strb,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic       SEL_S       = 1'b0;
    localparam logic       SEL_C       = 1'b1;
    localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);
    localparam logic [7:0] TIMEOUT_MAX = 8'(RSP_TIMEOUT);

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        owner_prev_q, owner_prev_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_strb_q, mem_strb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        s_gnt_q, s_gnt_d;
    logic        c_gnt_q, c_gnt_d;

    logic        own_req;
    logic        oth_req;
    logic        owner_flip;
    logic [3:0]  starve_eff;
    logic        starved;
    logic        win_own;
    logic        win_oth;
    logic        win;
    logic        win_id;
    logic        timeout;
    logic        resp_s;
    logic        resp_c;

    // Arbitration. A flip of bus_owner clears the starvation count in the
    // same cycle it is seen, so the old owner is never forced through as the
    // new non-owner on a count it earned while it was the owner.
    always_comb begin
        own_req    = bus_owner ? c_req : s_req;
        oth_req    = bus_owner ? s_req : c_req;
        owner_flip = (bus_owner != owner_prev_q);
        starve_eff = owner_flip ? 4'd0 : starve_q;
        starved    = (starve_eff == STARVE_MAX) && !owner_lock;
        win_oth    = oth_req && !owner_lock && (!own_req || starved);
        win_own    = own_req && !win_oth;
        win        = (state_q == ST_IDLE) && (win_own || win_oth);
        win_id     = win_oth ? ~bus_owner : bus_owner;
        timeout    = (wait_cnt_q == TIMEOUT_MAX);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            sel_q        <= SEL_S;
            starve_q     <= '0;
            wait_cnt_q   <= '0;
            owner_prev_q <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_strb_q   <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            s_gnt_q      <= 1'b0;
            c_gnt_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            starve_q     <= starve_d;
            wait_cnt_q   <= wait_cnt_d;
            owner_prev_q <= owner_prev_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_strb_q   <= mem_strb_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            s_gnt_q      <= s_gnt_d;
            c_gnt_q      <= c_gnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (mem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid || timeout) state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Starvation counter: counts owner wins taken over a waiting non-owner.
    always_comb begin
        owner_prev_d = bus_owner;
        starve_d     = starve_q;
        if (owner_lock || owner_flip) begin
            starve_d = '0;
        end else if (win && win_oth) begin
            starve_d = '0;
        end else if (win && win_own && oth_req && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Transaction latch, grant pulses, wait counter and response capture.
    always_comb begin
        sel_d       = sel_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_strb_d  = mem_strb_q;
        wait_cnt_d  = wait_cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        s_gnt_d     = 1'b0;
        c_gnt_d     = 1'b0;
        if (win) begin
            sel_d       = win_id;
            mem_wen_d   = win_id ? c_wen   : s_wen;
            mem_addr_d  = win_id ? c_addr  : s_addr;
            mem_wdata_d = win_id ? c_wdata : s_wdata;
            mem_strb_d  = win_id ? c_strb  : s_strb;
            s_gnt_d     = (win_id == SEL_S);
            c_gnt_d     = (win_id == SEL_C);
        end
        if (state_q == ST_ISSUE) begin
            wait_cnt_d = '0;
        end
        if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (mem_rvalid) begin
                rdata_d = mem_rdata;
                err_d   = 1'b0;
            end else if (timeout) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end
        end
    end

    // Outputs.
    always_comb begin
        resp_s    = (state_q == ST_RESP) && (sel_q == SEL_S);
        resp_c    = (state_q == ST_RESP) && (sel_q == SEL_C);
        busy      = (state_q != ST_IDLE);
        mem_req   = (state_q == ST_ISSUE);
        mem_wen   = mem_wen_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_strb  = mem_strb_q;
        s_gnt     = s_gnt_q;
        c_gnt     = c_gnt_q;
        s_rvalid  = resp_s;
        c_rvalid  = resp_c;
        s_rdata   = resp_s ? rdata_q : '0;
        c_rdata   = resp_c ? rdata_q : '0;
        s_err     = resp_s && err_q;
        c_err     = resp_c && err_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter
// (RSP_TIMEOUT=8, STARVE_LIMIT=4).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        bus_owner = 1'b0;
    logic        owner_lock = 1'b0;
    logic        s_req = 1'b0, s_wen = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic [3:0]  s_strb = '0;
    logic        s_gnt, s_rvalid, s_err;
    logic [31:0] s_rdata;
    logic        c_req = 1'b0, c_wen = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic [3:0]  c_strb = '0;
    logic        c_gnt, c_rvalid, c_err;
    logic [31:0] c_rdata;
    logic        mem_req, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    mem_bus_arbiter #(
        .RSP_TIMEOUT (8),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus_owner (bus_owner),
        .owner_lock(owner_lock),
        .s_req     (s_req),
        .s_wen     (s_wen),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_strb    (s_strb),
        .s_gnt     (s_gnt),
        .s_rvalid  (s_rvalid),
        .s_rdata   (s_rdata),
        .s_err     (s_err),
        .c_req     (c_req),
        .c_wen     (c_wen),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_strb    (c_strb),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .c_err     (c_err),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_strb  (mem_strb),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        int k;
        k = 0;
        tick();
        while (!(s_gnt || c_gnt) && k < 20) begin
            tick();
            k++;
        end
        chk("gnt_seen", 32'(s_gnt | c_gnt), 32'd1);
    endtask

    initial begin
        // Reset values
        #2 resetn = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_gnt", 32'({s_gnt, c_gnt}), 32'd0);
        chk("rst_rvalid", 32'({s_rvalid, c_rvalid}), 32'd0);
        chk("rst_err", 32'({s_err, c_err}), 32'd0);
        chk("rst_rdata", s_rdata | c_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_strb_wen", 32'({mem_strb, mem_wen}), 32'd0);
        resetn = 1'b1;
        tick();

        // Single read by S, owner S
        bus_owner = 1'b0;
        s_req = 1'b1; s_wen = 1'b0; s_addr = 32'h40;
        s_wdata = 32'h11; s_strb = 4'hF;
        tick();
        chk("rd_s_gnt", 32'(s_gnt), 32'd1);
        chk("rd_c_gnt", 32'(c_gnt), 32'd0);
        chk("rd_mem_req", 32'(mem_req), 32'd1);
        chk("rd_mem_addr", mem_addr, 32'h40);
        chk("rd_mem_wen", 32'(mem_wen), 32'd0);
        s_req = 1'b0; mem_gnt = 1'b1;
        tick();
        chk("rd_gnt_pulse", 32'(s_gnt), 32'd0);
        chk("rd_mem_req_off", 32'(mem_req), 32'd0);
        mem_gnt = 1'b0;
        tick();
        chk("rd_no_early_rvalid", 32'(s_rvalid), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        tick();
        chk("rd_s_rvalid", 32'(s_rvalid), 32'd1);
        chk("rd_s_rdata", s_rdata, 32'h12345678);
        chk("rd_s_err", 32'(s_err), 32'd0);
        chk("rd_c_rvalid", 32'(c_rvalid), 32'd0);
        mem_rvalid = 1'b0;
        tick();
        chk("rd_rvalid_pulse", 32'(s_rvalid), 32'd0);
        chk("rd_idle", 32'(busy), 32'd0);

        // Write by C, owner C, memory stalls mem_gnt for 3 cycles
        bus_owner = 1'b1;
        c_req = 1'b1; c_wen = 1'b1; c_addr = 32'h100;
        c_wdata = 32'hCAFEF00D; c_strb = 4'h3;
        tick();
        chk("wr_c_gnt", 32'(c_gnt), 32'd1);
        chk("wr_s_gnt", 32'(s_gnt), 32'd0);
        c_req = 1'b0; c_wen = 1'b0; c_addr = 32'hFFFFFFFC;
        c_wdata = 32'h0; c_strb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            chk("wr_mem_req", 32'(mem_req), 32'd1);
            chk("wr_mem_addr", mem_addr, 32'h100);
            chk("wr_mem_wdata", mem_wdata, 32'hCAFEF00D);
            chk("wr_mem_strb", 32'(mem_strb), 32'h3);
            chk("wr_mem_wen", 32'(mem_wen), 32'd1);
            mem_gnt = (i == 3);
            tick();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        tick();
        chk("wr_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("wr_c_err", 32'(c_err), 32'd0);
        chk("wr_s_rvalid", 32'(s_rvalid), 32'd0);
        mem_rvalid = 1'b0;
        tick();

        // Starvation: owner C, both requesting, memory always ready
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1;
        s_req = 1'b1; s_wen = 1'b0; s_addr = 32'h80;
        c_req = 1'b1; c_wen = 1'b0; c_addr = 32'h84;
        for (int i = 0; i < 10; i++) begin
            wait_gnt();
            chk($sformatf("starve_order_%0d", i), 32'(c_gnt),
                32'(exp_order[i]));
        end

        // Owner lock: S never granted
        owner_lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt();
            chk($sformatf("lock_gnt_c_%0d", i), 32'(c_gnt), 32'd1);
        end
        c_req = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lock_idle", 32'(busy), 32'd0);
            chk("lock_no_s_gnt", 32'(s_gnt), 32'd0);
        end
        owner_lock = 1'b0;
        tick();
        chk("unlock_s_gnt", 32'(s_gnt), 32'd1);
        s_req = 1'b0;
        tick();
        tick();
        chk("unlock_s_rvalid", 32'(s_rvalid), 32'd1);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();

        // Response timeout with RSP_TIMEOUT=8
        c_req = 1'b1; c_wen = 1'b0; c_addr = 32'h200;
        mem_gnt = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("to_c_gnt", 32'(c_gnt), 32'd1);
        c_req = 1'b0;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("to_not_yet", 32'(c_rvalid), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
        tick();
        chk("to_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("to_c_err", 32'(c_err), 32'd1);
        chk("to_c_rdata", c_rdata, 32'd0);
        chk("to_s_rvalid", 32'(s_rvalid), 32'd0);
        tick();
        chk("to_idle", 32'(busy), 32'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rsp_dropped", 32'({s_rvalid, c_rvalid}), 32'd0);
        chk("late_rsp_idle", 32'(busy), 32'd0);
        c_req = 1'b1; c_addr = 32'h204;
        tick();
        chk("after_to_gnt", 32'(c_gnt), 32'd1);
        c_req = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BADCAFE;
        tick();
        chk("after_to_rvalid", 32'(c_rvalid), 32'd1);
        chk("after_to_rdata", c_rdata, 32'h0BADCAFE);
        chk("after_to_err", 32'(c_err), 32'd0);
        mem_rvalid = 1'b0;
        tick();

        // Ownership flip 0 -> 1 during WAIT
        bus_owner = 1'b0;
        s_req = 1'b1; s_addr = 32'h300;
        tick();
        chk("flip_s_gnt", 32'(s_gnt), 32'd1);
        s_req = 1'b0; c_req = 1'b1; c_addr = 32'h304; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; bus_owner = 1'b1;
        tick();
        tick();
        chk("flip_busy", 32'(busy), 32'd1);
        chk("flip_no_c_gnt", 32'(c_gnt), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
        tick();
        chk("flip_s_rvalid", 32'(s_rvalid), 32'd1);
        chk("flip_s_rdata", s_rdata, 32'h5555AAAA);
        chk("flip_c_rvalid", 32'(c_rvalid), 32'd0);
        mem_rvalid = 1'b0; s_req = 1'b1;
        tick();
        tick();
        chk("flip_c_gnt", 32'(c_gnt), 32'd1);
        chk("flip_s_gnt_lost", 32'(s_gnt), 32'd0);
        chk("flip_mem_addr", mem_addr, 32'h304);
        c_req = 1'b0; s_req = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1;
        tick();
        chk("flip_c_rvalid_done", 32'(c_rvalid), 32'd1);
        mem_rvalid = 1'b0;
        tick();

        // Reset during WAIT
        c_req = 1'b1; c_addr = 32'h400;
        tick();
        c_req = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rstw_mem_req", 32'(mem_req), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_rvalid", 32'({s_rvalid, c_rvalid}), 32'd0);
        chk("rstw_mem_addr", mem_addr, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        chk("rstw_idle", 32'(busy), 32'd0);
        c_req = 1'b1; c_addr = 32'h404;
        tick();
        chk("rstw_c_gnt", 32'(c_gnt), 32'd1);
        chk("rstw_addr", mem_addr, 32'h404);
        c_req = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A50001;
        tick();
        chk("rstw_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("rstw_c_rdata", c_rdata, 32'hA5A50001);
        mem_rvalid = 1'b0;
        tick();
        chk("rstw_end_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
